// File: rtl/projectile_controller.sv
// projectile_controller: launches one shot from the player's row on a fire edge.
// The shot walks across the playfield columns and is resolved against the target
// bitmap in the far column. The result is a one-cycle hit or miss pulse.
// Optional feature macro: PROJ_SCORE_EN builds the 8-bit saturating hit score.
// Without it, score is tied to zero.
module projectile_controller #(
  parameter int unsigned COLS        = 8,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned COOLDOWN    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fire,
  input  logic [7:0]      player_row,
  input  logic [7:0]      target_row,
  output logic            is_firing,
  output logic [7:0]      proj_row,
  output logic [COLS-1:0] proj_col,
  output logic            hit,
  output logic            miss,
  output logic [7:0]      score
);

  localparam int unsigned STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned COOL_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int unsigned STEP_LAST = STEP_CYCLES - 1;
  localparam int unsigned COOL_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLY     = 2'd1,
    RESOLVE = 2'd2,
    COOL    = 2'd3
  } state_t;

  state_t            state;
  logic              fire_q;
  logic [STEP_W-1:0] step;
  logic [COOL_W-1:0] cool;
  logic              launch;
  logic              step_wrap;
  logic              resolve_now;
  logic              target_hit;
  logic [7:0]        low_bit;

  assign launch      = fire & ~fire_q;
  // Two's-complement trick isolates the lowest set row bit.
  assign low_bit     = player_row & (~player_row + 8'd1);
  assign step_wrap   = (step == STEP_W'(STEP_LAST));
  assign resolve_now = (state == FLY) && step_wrap && proj_col[COLS-1];
  assign target_hit  = |(proj_row & target_row);

  // Fire edge-detect history, tracked in every state so a held button never re-launches.
  always_ff @(posedge clk) begin
    if (!rst) fire_q <= 1'b0;
    else      fire_q <= fire;
  end

  // Shot sequencing: launch, column walk, resolution pulse and cooldown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      step      <= '0;
      cool      <= '0;
      is_firing <= 1'b0;
      proj_row  <= '0;
      proj_col  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (launch && (player_row != 8'd0)) begin
            state     <= FLY;
            is_firing <= 1'b1;
            proj_row  <= low_bit;
            proj_col  <= COLS'(1);
            step      <= '0;
          end
        end
        FLY: begin
          if (step_wrap) begin
            step <= '0;
            if (proj_col[COLS-1]) begin
              hit       <= target_hit;
              miss      <= ~target_hit;
              proj_row  <= '0;
              proj_col  <= '0;
              is_firing <= 1'b0;
              state     <= RESOLVE;
            end else begin
              proj_col <= {proj_col[COLS-2:0], 1'b0};
            end
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        RESOLVE: begin
          cool  <= '0;
          state <= (COOLDOWN == 0) ? IDLE : COOL;
        end
        COOL: begin
          if (cool == COOL_W'(COOL_LAST)) state <= IDLE;
          else                            cool  <= cool + COOL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROJ_SCORE_EN
  // Saturating hit counter, bumped on the resolving edge of a hit.
  always_ff @(posedge clk) begin
    if (!rst)                                          score <= 8'd0;
    else if (resolve_now && target_hit && score != 8'hFF) score <= score + 8'd1;
  end
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_projectile_controller.sv
// Testbench for projectile_controller (default parameters COLS=8, STEP_CYCLES=4, COOLDOWN=2).
// Expected shot results are queued at launch and compared when the DUT resolves the shot.
module tb_projectile_controller;

  logic       clk;
  logic       rst;
  logic       fire;
  logic [7:0] player_row;
  logic [7:0] target_row;
  logic       is_firing;
  logic [7:0] proj_row;
  logic [7:0] proj_col;
  logic       hit;
  logic       miss;
  logic [7:0] score;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] row;
    logic [7:0] score;
  } exp_t;

  exp_t       sb_q[$];
  int         checks;
  int         errors;
  logic [7:0] model_score;

  projectile_controller dut (
    .clk        (clk),
    .rst        (rst),
    .fire       (fire),
    .player_row (player_row),
    .target_row (target_row),
    .is_firing  (is_firing),
    .proj_row   (proj_row),
    .proj_col   (proj_col),
    .hit        (hit),
    .miss       (miss),
    .score      (score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Lowest set bit of a row, by scanning.
  function automatic logic [7:0] lowest(input logic [7:0] r);
    logic [7:0] res;
    res = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) res = 8'd1 << i;
    end
    return res;
  endfunction

  // Model the outcome of a shot and queue it.
  task automatic push_expect(input logic [7:0] row, input logic [7:0] tgt);
    exp_t e;
    e.row  = lowest(row);
    e.hit  = |(e.row & tgt);
    e.miss = ~e.hit;
`ifdef PROJ_SCORE_EN
    if (e.hit && model_score != 8'hFF) model_score = model_score + 8'd1;
`endif
    e.score = model_score;
    sb_q.push_back(e);
  endtask

  // Launch one shot and wait for its resolution; returns at the cycle IDLE is back.
  task automatic shot(input logic [7:0] row, input logic [7:0] tgt, output int lat,
                      output logic h, output logic m, output logic [7:0] sc,
                      output logic [7:0] first_row);
    @(negedge clk);
    player_row = row;
    target_row = tgt;
    fire       = 1'b1;
    push_expect(row, tgt);
    @(negedge clk);
    first_row = proj_row;
    fire      = 1'b0;
    lat       = 0;
    while (!(hit || miss) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    h  = hit;
    m  = miss;
    sc = score;
    if (lat >= 100) begin
      checks++;
      errors++;
      $display("FAIL shot_timeout: no hit/miss within %0d cycles", lat);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    fire       = 1'b0;
    player_row = 8'd0;
    target_row = 8'd0;
    model_score = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({is_firing, proj_row, proj_col, hit, miss, score} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got firing=%b row=%h col=%h hit=%b miss=%b score=%0d, want all 0",
               is_firing, proj_row, proj_col, hit, miss, score);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hit();
    exp_t e;
    @(negedge clk);
    player_row = 8'b0000_0100;
    target_row = 8'b0000_0100;
    fire       = 1'b1;
    push_expect(player_row, target_row);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) fire = 1'b0;
      checks++;
      if (is_firing !== 1'b1 || proj_col !== 8'(1 << (k / 4)) || proj_row !== 8'h04 ||
          hit !== 1'b0 || miss !== 1'b0) begin
        errors++;
        $display("FAIL hit_walk k=%0d: firing=%b col=%h row=%h hit=%b miss=%b, want 1 %h 04 0 0",
                 k, is_firing, proj_col, proj_row, hit, miss, 8'(1 << (k / 4)));
      end
    end
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (hit !== e.hit || miss !== e.miss) begin
      errors++;
      $display("FAIL hit_pulse: hit=%b miss=%b, want %b %b", hit, miss, e.hit, e.miss);
    end
    checks++;
    if (score !== e.score) begin
      errors++;
      $display("FAIL hit_score: got %0d want %0d", score, e.score);
    end
    checks++;
    if ({is_firing, proj_row, proj_col} !== 17'd0) begin
      errors++;
      $display("FAIL hit_clear: firing=%b row=%h col=%h, want 0", is_firing, proj_row, proj_col);
    end
    @(negedge clk);
    checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_cycle: hit=%b miss=%b one cycle later, want 0 0", hit, miss);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss();
    exp_t e;
    int lat;
    logic h, m;
    logic [7:0] sc, fr;
    shot(8'b0000_0100, 8'b0001_0000, lat, h, m, sc, fr);
    e = sb_q.pop_front();
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL miss_latency: got %0d want 32", lat);
    end
    checks++;
    if (h !== e.hit || m !== e.miss) begin
      errors++;
      $display("FAIL miss_pulse: hit=%b miss=%b, want %b %b", h, m, e.hit, e.miss);
    end
    checks++;
    if (sc !== e.score) begin
      errors++;
      $display("FAIL miss_score: got %0d want %0d", sc, e.score);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int fly_cnt;
    int pulses;
    fly_cnt = 0;
    pulses  = 0;
    @(negedge clk);
    player_row = 8'b0000_0100;
    target_row = 8'd0;
    fire       = 1'b1;
    push_expect(player_row, target_row);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 59) fire = 1'b0;
      if (is_firing) fly_cnt++;
      if (hit || miss) begin
        pulses++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
            errors++;
            $display("FAIL hold_result: hit=%b miss=%b score=%0d, want %b %b %0d",
                     hit, miss, score, e.hit, e.miss, e.score);
          end
        end
      end
    end
    checks++;
    if (fly_cnt != 32 || pulses != 1) begin
      errors++;
      $display("FAIL hold_single_launch: flying cycles=%0d pulses=%0d, want 32 1", fly_cnt, pulses);
    end
  endtask

  task automatic test_ignore();
    exp_t e;
    int quiet;
    @(negedge clk);
    player_row = 8'b0000_0100;
    target_row = 8'b0000_0100;
    fire       = 1'b1;
    push_expect(player_row, target_row);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) fire = 1'b0;
      if (k == 9) begin
        fire       = 1'b1;
        player_row = 8'b1000_0000;
      end
      if (k == 12) fire = 1'b0;
      checks++;
      if (proj_row !== 8'b0000_0100 || is_firing !== 1'b1) begin
        errors++;
        $display("FAIL ignore_row k=%0d: row=%h firing=%b, want 04 1", k, proj_row, is_firing);
      end
    end
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      errors++;
      $display("FAIL ignore_result: hit=%b miss=%b score=%0d, want %b %b %0d",
               hit, miss, score, e.hit, e.miss, e.score);
    end
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (is_firing) quiet++;
    end
    checks++;
    if (quiet != 0) begin
      errors++;
      $display("FAIL ignore_relaunch: flying cycles after resolve=%0d, want 0", quiet);
    end
  endtask

  task automatic test_no_launch();
    exp_t e;
    int lat;
    logic h, m;
    logic [7:0] sc, fr;
    @(negedge clk);
    player_row = 8'd0;
    target_row = 8'hFF;
    fire       = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (is_firing !== 1'b0 || proj_col !== 8'd0 || proj_row !== 8'd0) begin
      errors++;
      $display("FAIL empty_row_launch: firing=%b row=%h col=%h, want 0 00 00", is_firing, proj_row, proj_col);
    end
    fire = 1'b0;
    @(negedge clk);
    shot(8'b0110_0000, 8'b0010_0000, lat, h, m, sc, fr);
    e = sb_q.pop_front();
    checks++;
    if (fr !== e.row) begin
      errors++;
      $display("FAIL lowest_bit_row: got %h want %h", fr, e.row);
    end
    checks++;
    if (h !== e.hit || m !== e.miss || sc !== e.score || lat != 32) begin
      errors++;
      $display("FAIL lowest_bit_result: hit=%b miss=%b score=%0d lat=%0d, want %b %b %0d 32",
               h, m, sc, lat, e.hit, e.miss, e.score);
    end
  endtask

  task automatic test_reset_mid();
    int events;
    @(negedge clk);
    player_row = 8'b0000_0100;
    target_row = 8'b0000_0100;
    fire       = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) fire = 1'b0;
      if (k == 11) rst = 1'b0;
    end
    @(negedge clk);
    model_score = 8'd0;
    checks++;
    if ({is_firing, proj_row, proj_col, hit, miss, score} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_flight: firing=%b row=%h col=%h hit=%b miss=%b score=%0d, want all 0",
               is_firing, proj_row, proj_col, hit, miss, score);
    end
    rst    = 1'b1;
    events = 0;
    repeat (40) begin
      @(negedge clk);
      if (hit || miss || is_firing) events++;
    end
    checks++;
    if (events != 0) begin
      errors++;
      $display("FAIL reset_abort: activity cycles after reset=%0d, want 0", events);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int lat;
    logic h, m;
    logic [7:0] sc, fr;
    logic [7:0] final_exp;
    for (int i = 0; i < 256; i++) begin
      shot(8'b0000_0001, 8'hFF, lat, h, m, sc, fr);
      e = sb_q.pop_front();
      checks++;
      if (h !== e.hit || m !== e.miss || sc !== e.score) begin
        errors++;
        $display("FAIL saturate_shot %0d: hit=%b miss=%b score=%0d, want %b %b %0d",
                 i, h, m, sc, e.hit, e.miss, e.score);
      end
    end
`ifdef PROJ_SCORE_EN
    final_exp = 8'd255;
`else
    final_exp = 8'd0;
`endif
    checks++;
    if (score !== final_exp) begin
      errors++;
      $display("FAIL saturate_final: score=%0d want %0d", score, final_exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hit();
    test_miss();
    test_hold();
    test_ignore();
    test_no_launch();
    test_reset_mid();
    test_saturate();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
